// File: rtl/lcb_pkg.sv
// Shared constants, FSM encoding and byte-position helper for the LCB frame packer.
// A frame is 3 groups of {MSB byte, 4 LSB bytes}, each group carrying 4 measures.
package lcb_pkg;

  localparam int unsigned LCB_FRAME_BYTES    = 15;
  localparam int unsigned LCB_MEAS_PER_RQ    = 12;
  localparam int unsigned LCB_MEAS_PER_GROUP = 4;
  localparam int unsigned LCB_MEAS_W         = 10;
  localparam int unsigned LCB_WORD_W         = 12;
  localparam int unsigned LCB_RAM_DEPTH      = 384;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_GAP
  } lcb_state_e;

  typedef struct packed {
    logic [1:0] group;
    logic [2:0] slot;
  } lcb_byte_pos_t;

  // Slot 0 is the packed MSB byte; slots 1..4 are the low bytes of measures 0..3.
  function automatic lcb_byte_pos_t lcb_byte_pos(input logic [3:0] byte_idx);
    lcb_byte_pos_t pos;
    pos.group = 2'(byte_idx / 4'd5);
    pos.slot  = 3'(byte_idx % 4'd5);
    return pos;
  endfunction

endpackage

// File: rtl/lcb_frame_packer_if.sv
// Request, measure-RAM read and UART transmit signals of the LCB frame packer.
// master = the packer; slave = the surrounding system (requester, RAM, transmitter).
interface lcb_frame_packer_if;
  import lcb_pkg::*;

  logic                  rqStart;
  logic [4:0]            rqNumber;
  logic [8:0]            measAddr;
  logic                  measRdEn;
  logic [LCB_WORD_W-1:0] measData;
  logic [7:0]            txData;
  logic                  txStart;
  logic                  txBusy;
  logic                  busy;
  logic                  frameDone;

  modport master (
    input  rqStart, rqNumber, measData, txBusy,
    output measAddr, measRdEn, txData, txStart, busy, frameDone
  );

  modport slave (
    output rqStart, rqNumber, measData, txBusy,
    input  measAddr, measRdEn, txData, txStart, busy, frameDone
  );

endinterface

// File: rtl/lcb_rd_pipe.sv
// RD_LAT-deep valid/index shift register; out_valid/out_idx line up with the
// RAM word returned for the read issued RD_LAT clocks earlier.
module lcb_rd_pipe
  import lcb_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned IDX_W  = $clog2(LCB_MEAS_PER_RQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [IDX_W-1:0]  idx_q [RD_LAT];
  logic [IDX_W-1:0]  idx_d [RD_LAT];

  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    vld_d[0] = in_valid;
    idx_d[0] = in_idx;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_idx   = idx_q[RD_LAT-1];

endmodule

// File: rtl/lcb_frame_packer.sv
// LCB frame packer: fetches 12 measures for a request, packs them into the
// 15-byte LCB frame and streams it to the UART transmitter one byte at a time.
module lcb_frame_packer
  import lcb_pkg::*;
#(
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned GAP_CYCLES   = 16,
  parameter int unsigned WORDS_PER_RQ = LCB_MEAS_PER_RQ
) (
  input logic                clk,
  input logic                reset,
  lcb_frame_packer_if.master bus
);

  localparam int unsigned IDX_W     = 4;
  localparam int unsigned GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX  = 4'(LCB_MEAS_PER_RQ - 1);
  localparam logic [3:0]       LAST_BYTE = 4'(LCB_FRAME_BYTES - 1);
  localparam logic [3:0]       N_ISSUE   = 4'(WORDS_PER_RQ);

  lcb_state_e state_q, state_d;

  logic [8:0]            base_q, base_d;
  logic [3:0]            issue_cnt_q, issue_cnt_d;
  logic [8:0]            addr_q, addr_d;
  logic                  rd_en_q, rd_en_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [LCB_MEAS_W-1:0] meas_buf_q [LCB_MEAS_PER_RQ];
  logic [LCB_MEAS_W-1:0] meas_buf_d [LCB_MEAS_PER_RQ];
  logic [3:0]            byte_cnt_q, byte_cnt_d;
  logic [1:0]            wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  logic             pipe_valid;
  logic [IDX_W-1:0] pipe_idx;
  logic [8:0]       rq_base;
  lcb_byte_pos_t    byte_pos;
  logic [3:0]       grp_base;
  logic [3:0]       lsb_idx;
  logic [7:0]       cur_byte;

  lcb_rd_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (IDX_W)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_en_q),
    .in_idx    (rd_idx_q),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx)
  );

  // rqNumber*12 as a shift-add; 31*12 = 372 still fits in 9 bits.
  assign rq_base = {1'b0, bus.rqNumber, 3'b000} + {2'b00, bus.rqNumber, 2'b00};

  always_comb begin
    byte_pos = lcb_byte_pos(byte_cnt_q);
    grp_base = {byte_pos.group, 2'b00};
    lsb_idx  = grp_base + {1'b0, byte_pos.slot} - 4'd1;
    if (byte_pos.slot == 3'd0) begin
      cur_byte = {meas_buf_q[grp_base][9:8],
                  meas_buf_q[grp_base + 4'd1][9:8],
                  meas_buf_q[grp_base + 4'd2][9:8],
                  meas_buf_q[grp_base + 4'd3][9:8]};
    end else begin
      cur_byte = meas_buf_q[lsb_idx][7:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    issue_cnt_d  = issue_cnt_q;
    addr_d       = addr_q;
    rd_en_d      = 1'b0;
    rd_idx_d     = rd_idx_q;
    meas_buf_d   = meas_buf_q;
    byte_cnt_d   = byte_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    if (pipe_valid) meas_buf_d[pipe_idx] = bus.measData[10:1];

    unique case (state_q)
      ST_IDLE: begin
        // The frameDone cycle is still IDLE; holding off one clock keeps busy low for it.
        if (bus.rqStart && !frame_done_q) begin
          base_d      = rq_base;
          busy_d      = 1'b1;
          rd_en_d     = 1'b1;
          addr_d      = rq_base;
          rd_idx_d    = '0;
          issue_cnt_d = 4'd1;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (issue_cnt_q < N_ISSUE) begin
          rd_en_d     = 1'b1;
          addr_d      = base_q + 9'(issue_cnt_q);
          rd_idx_d    = issue_cnt_q;
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        if (pipe_valid && pipe_idx == LAST_IDX) begin
          byte_cnt_d = '0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!bus.txBusy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (bus.txBusy) begin
          state_d = ST_WAIT_LO;
        end else if (wait_cnt_q == 2'd3) begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      ST_WAIT_LO: begin
        if (!bus.txBusy) begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (byte_cnt_q == LAST_BYTE) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            byte_cnt_d   = '0;
            state_d      = ST_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
            state_d    = ST_LOAD;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      issue_cnt_q  <= '0;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      rd_idx_q     <= '0;
      for (int unsigned i = 0; i < LCB_MEAS_PER_RQ; i++) meas_buf_q[i] <= '0;
      byte_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      issue_cnt_q  <= issue_cnt_d;
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      rd_idx_q     <= rd_idx_d;
      meas_buf_q   <= meas_buf_d;
      byte_cnt_q   <= byte_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.measAddr  = addr_q;
  assign bus.measRdEn  = rd_en_q;
  assign bus.txData    = tx_data_q;
  assign bus.txStart   = tx_start_q;
  assign bus.busy      = busy_q;
  assign bus.frameDone = frame_done_q;

endmodule

// File: tb/tb_lcb_frame_packer.sv
// Scoreboard bench for lcb_frame_packer: stimulus pushes expected addresses and
// bytes, a negedge monitor pops and compares whenever the DUT reads or transmits.
module tb_lcb_frame_packer;
  import lcb_pkg::*;

  localparam int unsigned GAP = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcb_frame_packer_if bus();

  lcb_frame_packer #(
    .RD_LAT     (2),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] mem [384];
  logic [8:0]  ram_a1;
  logic        ram_v1;
  int          tx_cnt;
  bit          tx_stuck = 0;
  bit          tx_force_high = 0;

  logic [8:0] exp_addr_q [$];
  logic [7:0] exp_byte_q [$];
  logic [7:0] rx_q [$];
  int          frames_done = 0;
  int          tx_count = 0;
  int unsigned cyc = 0;
  int unsigned last_tx_cyc = 0;
  bit          chk_interval = 0;
  int unsigned expect_interval = 0;
  logic [7:0]  held_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Measure RAM with two clocks of read latency.
  always @(posedge clk) begin
    ram_a1       <= bus.measAddr;
    ram_v1       <= bus.measRdEn;
    bus.measData <= ram_v1 ? mem[ram_a1] : 12'hABC;
  end

  // Transmitter: busy for 10 clocks after each txStart unless stuck low or forced high.
  initial tx_cnt = 0;
  always @(posedge clk) begin
    if (bus.txStart && !tx_stuck) tx_cnt <= 10;
    else if (tx_cnt > 0)          tx_cnt <= tx_cnt - 1;
  end
  assign bus.txBusy = tx_force_high | (tx_cnt != 0);

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.measRdEn) begin
        check("rd_pending", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) check("measAddr", 32'(bus.measAddr), 32'(exp_addr_q.pop_front()));
      end
      if (bus.txStart) begin
        check("tx_pending", 32'(exp_byte_q.size() != 0), 32'd1);
        if (exp_byte_q.size() != 0) check("txData", 32'(bus.txData), 32'(exp_byte_q.pop_front()));
        rx_q.push_back(bus.txData);
        held_byte = bus.txData;
        tx_count++;
        if (chk_interval && tx_count > 1) check("tx_interval", cyc - last_tx_cyc, expect_interval);
        last_tx_cyc = cyc;
      end else if (bus.txBusy && bus.busy && !tx_force_high) begin
        check("txData_hold", 32'(bus.txData), 32'(held_byte));
      end
      if (bus.frameDone) begin
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("bytes_left_at_done", 32'(exp_byte_q.size()), 32'd0);
        frames_done++;
      end
    end
  end

  task automatic request(input logic [4:0] n);
    @(negedge clk);
    bus.rqStart  = 1'b1;
    bus.rqNumber = n;
    @(negedge clk);
    bus.rqStart  = 1'b0;
  endtask

  task automatic push_frame(input int unsigned base);
    logic [9:0] m [12];
    for (int k = 0; k < 12; k++) begin
      exp_addr_q.push_back(9'(base + 32'(k)));
      m[k] = mem[base + 32'(k)][10:1];
    end
    for (int g = 0; g < 3; g++) begin
      exp_byte_q.push_back({m[4*g][9:8], m[4*g+1][9:8], m[4*g+2][9:8], m[4*g+3][9:8]});
      for (int i = 0; i < 4; i++) exp_byte_q.push_back(m[4*g+i][7:0]);
    end
  endtask

  task automatic wait_frame(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", 32'(frames_done >= target), 32'd1);
  endtask

  initial begin
    logic [7:0] t1 [15];
    logic [7:0] msb;
    logic [9:0] meas;
    int n;

    t1 = '{8'hFF, 8'hFF, 8'hFE, 8'hFD, 8'hFC,
           8'hFF, 8'hFB, 8'hFA, 8'hF9, 8'hF8,
           8'hFF, 8'hF7, 8'hF6, 8'hF5, 8'hF4};
    for (int a = 0; a < 384; a++) begin
      if (a < 12) mem[a] = {1'b0, 10'(1023 - a), 1'b0};
      else        mem[a] = {1'b1, 10'(a * 37 + 5), 1'b1};
    end

    // Reset held 3 clocks with rqStart high: nothing may happen.
    bus.rqStart  = 1'b1;
    bus.rqNumber = 5'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_measAddr",  32'(bus.measAddr),  32'd0);
    check("rst_measRdEn",  32'(bus.measRdEn),  32'd0);
    check("rst_txData",    32'(bus.txData),    32'd0);
    check("rst_txStart",   32'(bus.txStart),   32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_frameDone", 32'(bus.frameDone), 32'd0);
    reset        = 1'b0;
    bus.rqStart  = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    // Request 0 with hand-computed bytes.
    for (int k = 0; k < 12; k++) exp_addr_q.push_back(9'(k));
    for (int b = 0; b < 15; b++) exp_byte_q.push_back(t1[b]);
    tx_count = 0;
    request(5'd0);
    check("busy_after_rq", 32'(bus.busy), 32'd1);
    wait_frame(1, 2000);
    repeat (30) @(negedge clk);
    check("f1_bytes", 32'(tx_count), 32'd15);
    check("f1_frames", 32'(frames_done), 32'd1);

    // Request 31: top of RAM, then re-decode the frame.
    rx_q.delete();
    tx_count = 0;
    push_frame(372);
    request(5'd31);
    wait_frame(2, 2000);
    check("f2_rx_len", 32'(rx_q.size()), 32'd15);
    if (rx_q.size() >= 15) begin
      for (int g = 0; g < 3; g++) begin
        msb = rx_q[5*g];
        for (int i = 0; i < 4; i++) begin
          meas = {msb[7-2*i -: 2], rx_q[5*g+1+i]};
          check("decode_meas", 32'(meas), 32'(mem[372 + 4*g + i][10:1]));
        end
      end
    end

    // Request 1 with a second request mid-frame that must be ignored.
    tx_count = 0;
    push_frame(12);
    request(5'd1);
    n = 0;
    while (tx_count < 3 && n < 2000) begin @(negedge clk); n++; end
    check("f3_progress", 32'(tx_count >= 3), 32'd1);
    request(5'd5);
    wait_frame(3, 2000);
    repeat (60) @(negedge clk);
    check("f3_bytes", 32'(tx_count), 32'd15);
    check("f3_frames", 32'(frames_done), 32'd3);

    // Transmitter stuck low: 4-clock fallback + gap + load per byte.
    tx_stuck        = 1;
    chk_interval    = 1;
    expect_interval = 4 + GAP + 1;
    tx_count        = 0;
    push_frame(36);
    request(5'd3);
    wait_frame(4, 2000);
    chk_interval = 0;
    check("f4_bytes", 32'(tx_count), 32'd15);
    tx_stuck = 0;

    // Transmitter held busy for 200 clocks: no byte may launch.
    tx_force_high = 1;
    tx_count      = 0;
    push_frame(48);
    request(5'd4);
    repeat (200) @(negedge clk);
    check("no_tx_while_busy", 32'(tx_count), 32'd0);
    tx_force_high = 0;
    wait_frame(5, 2000);
    check("f5_bytes", 32'(tx_count), 32'd15);

    // Reset after byte 7 aborts the frame, then a clean request 2.
    tx_count = 0;
    push_frame(72);
    request(5'd6);
    n = 0;
    while (tx_count < 8 && n < 2000) begin @(negedge clk); n++; end
    check("f6_byte7_seen", 32'(tx_count >= 8), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    exp_byte_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_txStart", 32'(bus.txStart), 32'd0);
    repeat (60) @(negedge clk);
    check("abort_bytes", 32'(tx_count), 32'd8);
    check("abort_frames", 32'(frames_done), 32'd5);
    check("abort_addr_left", 32'(exp_addr_q.size()), 32'd0);

    tx_count = 0;
    push_frame(24);
    request(5'd2);
    wait_frame(6, 2000);
    check("f7_bytes", 32'(tx_count), 32'd15);
    check("f7_addr_left", 32'(exp_addr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

endmodule
